// File: rtl/viterbi_pkg.sv
// Shared constants, types and branch-symbol helpers for the rate-1/2, K=3 codec.
package viterbi_pkg;

  localparam logic [2:0] G0         = 3'b111;
  localparam logic [2:0] G1         = 3'b101;
  localparam int         NUM_STATES = 4;
  localparam int         PM_W_DEF   = 4;

  typedef logic [1:0]          state_t;
  typedef logic [1:0]          symbol_t;
  typedef logic [PM_W_DEF-1:0] metric_t;

  // Symbol produced when bit d enters an encoder holding s = {b[n-1], b[n-2]}.
  function automatic symbol_t expected_symbol(state_t s, logic d);
    logic [2:0] taps;
    taps = {d, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic logic [1:0] hamming2(symbol_t a, symbol_t b);
    symbol_t x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_codec_if.sv
// Link-side bundle of the codec: serial transmit bits in, encoded symbols and decoded bits out.
interface viterbi_codec_if;
  // Handshake: tx_en is a pure qualifier with no back-pressure; tx_bit and err_mask are
  // taken on every rising edge where tx_en is high, and enc_valid pulses for one cycle per
  // accepted bit. dec_bit is a level that only changes when the decoder consumes a symbol.
  logic       tx_en;
  logic       tx_bit;
  logic [1:0] err_mask;
  logic       enc_valid;
  logic [1:0] enc_sym;
  logic       dec_bit;

  modport master (output tx_en, tx_bit, err_mask, input  enc_valid, enc_sym, dec_bit);
  modport slave  (input  tx_en, tx_bit, err_mask, output enc_valid, enc_sym, dec_bit);
endinterface

// File: rtl/decoder.sv
// 4-state hard-decision Viterbi decoder with register-exchange survivors.
// Define VITERBI_ASSERT_EN to compile in simulation-only input and metric assertions.
module decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = PM_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    enable,
  input  symbol_t d_in,
  output logic    d_out
);

  localparam logic [PM_W:0]   PM_MAX  = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(8);

  logic [PM_W-1:0]       pm_q   [NUM_STATES];
  logic [PM_W-1:0]       pm_d   [NUM_STATES];
  logic [TB_DEPTH-1:0]   path_q [NUM_STATES];
  logic [TB_DEPTH-1:0]   path_d [NUM_STATES];
  logic [PM_W:0]         acc    [NUM_STATES];
  logic [NUM_STATES-1:0] dec;
  logic [PM_W:0]         min_sum;
  logic [PM_W:0]         norm;
  state_t                best;
  logic                  d_out_d;

  // State {d, x} is reached from {x, 0} and {x, 1} by shifting in bit d.
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam int   P0 = (s % 2) * 2;
    localparam logic D  = 1'(s / 2);
    logic [1:0] bm_a;
    logic [1:0] bm_b;

    assign bm_a = hamming2(d_in, expected_symbol(state_t'(P0), D));
    assign bm_b = hamming2(d_in, expected_symbol(state_t'(P0 + 1), D));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm_a   (pm_q[P0]),
      .pm_b   (pm_q[P0+1]),
      .bm_a   (bm_a),
      .bm_b   (bm_b),
      .pm_sum (acc[s]),
      .dec    (dec[s])
    );

    assign path_d[s] = {(dec[s] ? path_q[P0+1][TB_DEPTH-2:0] : path_q[P0][TB_DEPTH-2:0]), D};
  end

  always_comb begin
    min_sum = acc[0];
    norm    = '0;
    best    = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (acc[s] < min_sum) min_sum = acc[s];
    end
    for (int s = 0; s < NUM_STATES; s++) begin
      norm    = acc[s] - min_sum;
      pm_d[s] = (norm > PM_MAX) ? PM_MAX[PM_W-1:0] : norm[PM_W-1:0];
    end
    // Downward scan so the lowest-index zero-metric state wins.
    for (int s = NUM_STATES - 1; s >= 0; s--) begin
      if (pm_d[s] == '0) best = state_t'(s);
    end
    d_out_d = path_d[best][TB_DEPTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        path_q[s] <= '0;
      end
      d_out <= 1'b0;
    end else if (enable) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= pm_d[s];
        path_q[s] <= path_d[s];
      end
      d_out <= d_out_d;
    end
  end

`ifdef VITERBI_ASSERT_EN
  always @(posedge clk) begin
    if (rst && enable) begin
      assert (!$isunknown(d_in)) else $error("decoder: X on d_in while enabled");
      assert (pm_d[0] == '0 || pm_d[1] == '0 || pm_d[2] == '0 || pm_d[3] == '0)
        else $error("decoder: normalized minimum metric is not zero");
      // A zero minimum sum means the received stream still matches some code path.
      if (min_sum == '0) begin
        for (int s = 0; s < NUM_STATES; s++) begin
          assert ({1'b0, pm_d[s]} < PM_MAX) else $error("decoder: metric saturated on clean input");
        end
      end
    end
  end
`else
`endif

endmodule

// File: rtl/encoder.sv
// Rate-1/2, K=3 convolutional encoder (generators 7, 5 octal), one symbol per enabled edge.
module encoder
  import viterbi_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    enable_i,
  input  logic    d_in,
  output logic    valid_o,
  output symbol_t d_out
);

  state_t state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      d_out   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out   <= expected_symbol(state_q, d_in);
        state_q <= {d_in, state_q[1]};
      end
    end
  end

endmodule

// File: rtl/viterbi_acs.sv
// Two-way add-compare-select for one trellis state; ties resolve to predecessor a (LSB 0).
module viterbi_acs #(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W:0]   pm_sum,
  output logic            dec
);

  logic [PM_W:0] sum_a;
  logic [PM_W:0] sum_b;

  // One guard bit so the sum never wraps before normalization and saturation.
  assign sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
  assign sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
  assign dec    = (sum_b < sum_a);
  assign pm_sum = dec ? sum_b : sum_a;

endmodule

// File: rtl/viterbi_codec.sv
// Codec link: encoder -> registered channel with error injection -> Viterbi decoder.
// Decoder assertions are compiled in with VITERBI_ASSERT_EN.
module viterbi_codec
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = PM_W_DEF
) (
  input logic            clk,
  input logic            rst,
  viterbi_codec_if.slave link
);

  logic    enc_valid;
  symbol_t enc_sym;
  symbol_t err_q;
  logic    chan_valid;
  symbol_t chan_sym;

  encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (link.tx_en),
    .d_in     (link.tx_bit),
    .valid_o  (enc_valid),
    .d_out    (enc_sym)
  );

  // err_mask is captured with its bit so the flip lands on that bit's symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= '0;
      chan_valid <= 1'b0;
      chan_sym   <= '0;
    end else begin
      if (link.tx_en) err_q <= link.err_mask;
      chan_valid <= enc_valid;
      if (enc_valid) chan_sym <= enc_sym ^ err_q;
    end
  end

  decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) u_dec (
    .clk    (clk),
    .rst    (rst),
    .enable (chan_valid),
    .d_in   (chan_sym),
    .d_out  (link.dec_bit)
  );

  assign link.enc_valid = enc_valid;
  assign link.enc_sym   = enc_sym;

endmodule

// File: tb/tb_viterbi_codec.sv
// Self-checking bench for viterbi_codec: random streams against a bit-level reference model.
module tb_viterbi_codec;

  localparam int LAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  // Reference model state: decoded-bit scoreboard and encoder bit history.
  logic [0:0] exp_q[$];
  logic       ref_bits[$];
  logic       hist1, hist2;
  logic [1:0] sym_m;
  logic       en_d1, en_d2;
  logic       dec_m;

  viterbi_codec_if ifc ();

  viterbi_codec #(.TB_DEPTH(16), .PM_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(1'b0);
    hist1 = 1'b0;
    hist2 = 1'b0;
    sym_m = 2'b00;
    en_d1 = 1'b0;
    en_d2 = 1'b0;
    dec_m = 1'b0;
  endtask

  task automatic hold_reset();
    ifc.tx_en    = 1'b0;
    ifc.tx_bit   = 1'b0;
    ifc.err_mask = 2'b00;
    rst = 1'b0;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drives one cycle and returns what the link should show 1 time unit after the edge.
  // A bit accepted at edge k is encoded at k, crosses the channel at k+1, decoded at k+2.
  task automatic drive_cycle(input logic en, input logic b, input logic [1:0] mask,
                             output logic exp_valid, output logic [1:0] exp_sym,
                             output logic consumed, output logic exp_dec);
    ifc.tx_en    = en;
    ifc.tx_bit   = b;
    ifc.err_mask = mask;
    @(posedge clk);
    consumed = en_d2;
    if (consumed) dec_m = exp_q.pop_front();
    en_d2 = en_d1;
    en_d1 = en;
    if (en) begin
      sym_m = {b ^ hist1 ^ hist2, b ^ hist2};
      hist2 = hist1;
      hist1 = b;
      exp_q.push_back(b);
    end
    exp_valid = en;
    exp_sym   = sym_m;
    exp_dec   = dec_m;
    #1;
  endtask

  task automatic test_reset();
    hold_reset();
    checks++;
    if (ifc.enc_valid !== 1'b0) $display("FAIL reset_enc_valid got %b expected 0", ifc.enc_valid); else passed++;
    checks++;
    if (ifc.enc_sym !== 2'b00) $display("FAIL reset_enc_sym got %b expected 00", ifc.enc_sym); else passed++;
    checks++;
    if (ifc.dec_bit !== 1'b0) $display("FAIL reset_dec_bit got %b expected 0", ifc.dec_bit); else passed++;
    release_reset();
  endtask

  task automatic test_encoder();
    logic       bits [3];
    logic [1:0] syms [3];
    logic       ev, cons, ed;
    logic [1:0] es;
    bits = '{1'b1, 1'b0, 1'b0};
    syms = '{2'b11, 2'b10, 2'b11};
    hold_reset();
    release_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, bits[i], 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.enc_valid !== 1'b1) $display("FAIL enc_valid i=%0d got %b expected 1", i, ifc.enc_valid); else passed++;
      checks++;
      if (ifc.enc_sym !== syms[i]) $display("FAIL enc_sym i=%0d got %b expected %b", i, ifc.enc_sym, syms[i]); else passed++;
    end
    drive_cycle(1'b0, 1'b1, 2'b00, ev, es, cons, ed);
    checks++;
    if (ifc.enc_valid !== 1'b0) $display("FAIL enc_idle_valid got %b expected 0", ifc.enc_valid); else passed++;
    checks++;
    if (ifc.enc_sym !== 2'b11) $display("FAIL enc_idle_hold got %b expected 11", ifc.enc_sym); else passed++;
  endtask

  task automatic test_loopback();
    logic ev, cons, ed, b;
    logic [1:0] es;
    hold_reset();
    release_reset();
    ref_bits.delete();
    for (int i = 0; i < 256 + 3; i++) begin
      b = 1'($urandom_range(0, 1));
      if (i < 256) ref_bits.push_back(b);
      drive_cycle(i < 256, b, 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.enc_valid !== ev) $display("FAIL loop_enc_valid i=%0d got %b expected %b", i, ifc.enc_valid, ev); else passed++;
      checks++;
      if (ifc.enc_sym !== es) $display("FAIL loop_enc_sym i=%0d got %b expected %b", i, ifc.enc_sym, es); else passed++;
      checks++;
      if (ifc.dec_bit !== ed) $display("FAIL loop_dec_bit i=%0d got %b expected %b", i, ifc.dec_bit, ed); else passed++;
    end
  endtask

  task automatic test_error_injection();
    logic ev, cons, ed, b;
    logic [1:0] es;
    hold_reset();
    release_reset();
    for (int i = 0; i < 256 + 3; i++) begin
      b = 1'($urandom_range(0, 1));
      drive_cycle(i < 256, b, (i % 8 == 7) ? 2'b01 : 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.dec_bit !== ed) $display("FAIL errinj_dec_bit i=%0d got %b expected %b", i, ifc.dec_bit, ed); else passed++;
    end
  endtask

  task automatic test_enable_gaps();
    logic ev, cons, ed;
    logic [1:0] es;
    int gap;
    hold_reset();
    release_reset();
    for (int i = 0; i < ref_bits.size(); i++) begin
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      for (int g = 0; g < gap; g++) begin
        drive_cycle(1'b0, 1'($urandom_range(0, 1)), 2'b00, ev, es, cons, ed);
        checks++;
        if (ifc.enc_valid !== 1'b0) $display("FAIL gap_enc_valid i=%0d got %b expected 0", i, ifc.enc_valid); else passed++;
        checks++;
        if (ifc.dec_bit !== ed) $display("FAIL gap_dec_bit i=%0d got %b expected %b", i, ifc.dec_bit, ed); else passed++;
      end
      drive_cycle(1'b1, ref_bits[i], 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.enc_sym !== es) $display("FAIL gap_enc_sym i=%0d got %b expected %b", i, ifc.enc_sym, es); else passed++;
      checks++;
      if (ifc.dec_bit !== ed) $display("FAIL gap_dec_after i=%0d got %b expected %b", i, ifc.dec_bit, ed); else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    logic ev, cons, ed, b;
    logic [1:0] es;
    hold_reset();
    release_reset();
    for (int i = 0; i < 100; i++) begin
      b = 1'($urandom_range(0, 1));
      drive_cycle(1'b1, b, 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.dec_bit !== ed) $display("FAIL pre_reset_dec i=%0d got %b expected %b", i, ifc.dec_bit, ed); else passed++;
    end
    hold_reset();
    checks++;
    if (ifc.enc_valid !== 1'b0) $display("FAIL mid_reset_enc_valid got %b expected 0", ifc.enc_valid); else passed++;
    checks++;
    if (ifc.enc_sym !== 2'b00) $display("FAIL mid_reset_enc_sym got %b expected 00", ifc.enc_sym); else passed++;
    checks++;
    if (ifc.dec_bit !== 1'b0) $display("FAIL mid_reset_dec_bit got %b expected 0", ifc.dec_bit); else passed++;
    release_reset();
    for (int i = 0; i < 128 + LAT + 3; i++) begin
      b = 1'($urandom_range(0, 1));
      drive_cycle(i < 128 + LAT, b, 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.enc_sym !== es) $display("FAIL post_reset_enc_sym i=%0d got %b expected %b", i, ifc.enc_sym, es); else passed++;
      checks++;
      if (ifc.dec_bit !== ed) $display("FAIL post_reset_dec i=%0d got %b expected %b", i, ifc.dec_bit, ed); else passed++;
    end
  endtask

  task automatic test_all_zero_errors();
    logic ev, cons, ed;
    logic [1:0] es;
    hold_reset();
    release_reset();
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b1, 1'b0, (i % 8 == 3) ? 2'b01 : 2'b00, ev, es, cons, ed);
      checks++;
      if (ifc.dec_bit !== 1'b0) $display("FAIL zero_dec_bit i=%0d got %b expected 0", i, ifc.dec_bit); else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_encoder();
    test_loopback();
    test_error_injection();
    test_enable_gaps();
    test_reset_midstream();
    test_all_zero_errors();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
